mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- E-stage multiply/divide unit (MDU) owning the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, plus MTHI/MTLO writes and MFHI/MFLO reads.
- Drives `Busy` into the hazard/stall unit; the stall unit combines it with `E_Start` to freeze D whenever a HI/LO-touching instruction sits in D.
- `E_MDUOut` feeds the E-stage result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5: Busy cycles after a multiply start (range 1..15).
- DIV_CYCLES, 10: Busy cycles after a divide start (range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- E_MDUOp  in  4  operation code of the E-stage instruction (encodings in mdu_pkg).
- E_Start  in  1  one-cycle pulse; the E-stage instruction is MULT/MULTU/DIV/DIVU (or MADD-family when enabled).
- E_A  in  32  rs operand (forwarded).
- E_B  in  32  rt operand (forwarded).
- Busy  out  1  high while a started operation is in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- E_MDUOut  out  32  HI if op=MFHI, LO if op=MFLO, else 0 (combinational).

Behaviour:
- Reset (reset_n low, async):
  - Busy=0, HI=0, LO=0, counter=0, pending results=0, state=IDLE.
  - Reset asserted mid-operation aborts the operation; pending results are discarded.
- States: IDLE and RUN.
- IDLE, E_Start=1 with a mult/div op:
  - Compute the 64-bit result combinationally from E_A/E_B and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - Busy rises at the following edge.
- RUN:
  - Counter decrements every cycle.
  - On the edge where counter goes 1 -> 0: HI<=pending_hi, LO<=pending_lo, Busy<=0, state<=IDLE.
  - Busy is high for exactly the configured number of cycles.
- Results are never visible early: HI/LO keep their old values throughout RUN.
- E_Start during RUN: ignored (the stall unit guarantees this cannot happen). The bench asserts it never occurs.
- E_Start with a non-start op: ignored.
- MTHI/MTLO in IDLE: HI or LO <= E_A at the next edge, no Busy. In RUN: ignored.
- MFHI/MFLO: E_MDUOut reflects the current register value; no bypass of a same-cycle MTHI/MTLO.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {HI,LO}.
  - MULTU: unsigned 32x32 -> 64, {HI,LO}.
  - DIV: signed, truncating toward zero; LO=quotient, HI=remainder (sign follows dividend).
  - DIVU: unsigned; LO=quotient, HI=remainder.
- Divide by zero (DIV and DIVU): LO=32'hFFFFFFFF, HI=E_A; normal latency.
- DIV with 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU.
  - {HI,LO} <= {HI,LO} ± (E_A*E_B), signed or unsigned product, modulo 2^64.
  - Sampled HI/LO are the values at start time; latency MULT_CYCLES.
- Undefined: those encodings behave as no-op; E_Start with them is ignored.

Decomposition:
- mdu_pkg:
  - 4-bit op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - State encoding and default latency constants.
- One natural sub-module, mdu_arith: purely combinational; op, A, B, HI, LO in -> 64-bit result out. Contains all sign, zero-divide and overflow rules.
- The top level holds the FSM, counter and registers.

Test Plan:
- MULT, A=32'hFFFFFFFD (-3), B=7, Start pulse:
  - Busy high exactly 5 cycles.
  - HI/LO unchanged until the final edge, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- DIV, A=-7, B=2:
  - After 10 Busy cycles, LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU, A=7, B=0:
  - LO=32'hFFFFFFFF, HI=7 after 10 cycles.
  - DIV 32'h80000000 / -1 gives LO=32'h80000000, HI=0.
- MTHI A=32'h12345678 in IDLE; next cycle MFHI:
  - E_MDUOut=32'h12345678, Busy stays 0.
  - MTLO issued during RUN leaves LO untouched.
- Start DIV, drop reset_n on cycle 4 of RUN:
  - Busy=0, HI=LO=0 immediately.
  - After release, no late commit occurs.
- MDU_MADD_EN defined, HI=0, LO=32'hFFFFFFFF, MADDU A=1, B=1:
  - After 5 cycles HI=1, LO=0.
  - Without the macro, HI/LO are unchanged and Busy stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, latencies.
// The MDU_MADD_EN macro enables the MADD/MADDU/MSUB/MSUBU start ops.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 4;

    // Ops that occupy the unit for a multi-cycle latency when started.
    function automatic logic is_start_op(mdu_op_e op);
        logic start;
        start = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        start = start || (op == OP_MADD) || (op == OP_MADDU) ||
                (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return start;
    endfunction

    function automatic logic is_div_op(mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for all MDU arithmetic ops, including
// divide-by-zero and signed-overflow rules. MDU_MADD_EN adds accumulate ops.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic        [31:0] b_safe;
    logic signed [31:0] s_quo;
    logic signed [31:0] s_rem;
    logic        [31:0] u_quo;
    logic        [31:0] u_rem;
    logic               div_zero;
    logic               div_ovf;

    assign s_prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign u_prod   = {32'd0, a} * {32'd0, b};
    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // The divider never sees zero or the overflowing pair; those cases are muxed in below.
    assign b_safe = (div_zero || div_ovf) ? 32'd1 : b;
    assign s_quo  = $signed(a) / $signed(b_safe);
    assign s_rem  = $signed(a) % $signed(b_safe);
    assign u_quo  = a / b_safe;
    assign u_rem  = a % b_safe;

    // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result = 64'd0;
        unique case (op)
            OP_MULT:  result = s_prod;
            OP_MULTU: result = u_prod;
            OP_DIV: begin
                if (div_zero)     result = {a, 32'hFFFF_FFFF};
                else if (div_ovf) result = {32'd0, 32'h8000_0000};
                else              result = {s_rem, s_quo};
            end
            OP_DIVU: begin
                if (div_zero) result = {a, 32'hFFFF_FFFF};
                else          result = {u_rem, u_quo};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi, lo} + s_prod;
            OP_MADDU: result = {hi, lo} + u_prod;
            OP_MSUB:  result = {hi, lo} - s_prod;
            OP_MSUBU: result = {hi, lo} - u_prod;
`endif
            default:  result = 64'd0;
        endcase
    end

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO: FSM, latency counter and result commit.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MDUOut
);

    mdu_op_e          op;
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;
    logic [63:0]      arith_res;

    assign op = mdu_op_e'(E_MDUOp);

    // Accumulate ops read the architectural HI/LO as they stand at start time.
    mdu_arith u_arith (
        .op     (op),
        .a      (E_A),
        .b      (E_B),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (arith_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (E_Start && is_start_op(op)) begin
                    pend_d  = arith_res;
                    cnt_d   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = ST_RUN;
                end else if (op == OP_MTHI) begin
                    hi_d = E_A;
                end else if (op == OP_MTLO) begin
                    lo_d = E_A;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = pend_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        E_MDUOut = 32'd0;
        if (op == OP_MFHI)      E_MDUOut = hi_q;
        else if (op == OP_MFLO) E_MDUOut = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed expected values.
// Covers the MDU_MADD_EN build as well as the default build.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  E_MDUOp;
    logic        E_Start;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_MDUOut;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .E_MDUOp  (E_MDUOp),
        .E_Start  (E_Start),
        .E_A      (E_A),
        .E_B      (E_B),
        .Busy     (Busy),
        .HI       (HI),
        .LO       (LO),
        .E_MDUOut (E_MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // The stall unit must never present a start while the unit is busy.
    always @(negedge clk) begin
        if (E_Start && Busy) check("start_during_run", 1'b1, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        E_MDUOp = op;
        E_A     = a;
        E_B     = b;
        E_Start = 1'b1;
        tick();
        E_Start = 1'b0;
        E_MDUOp = OP_NONE;
    endtask

    task automatic move_to(input mdu_op_e op, input logic [31:0] a);
        E_MDUOp = op;
        E_A     = a;
        tick();
        E_MDUOp = OP_NONE;
    endtask

    // Starts an op, counts Busy cycles, flags any early HI/LO change, then checks the commit.
    task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   n;
        logic early;
        n     = 0;
        early = 1'b0;
        issue(op, a, b);
        while (Busy && n < 40) begin
            n++;
            if (HI !== m_hi || LO !== m_lo) early = 1'b1;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(cycles));
        check({tag, "_early"}, 64'(early), 64'd0);
        check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic bad;
        reset_n = 1'b0;
        E_Start = 1'b0;
        E_MDUOp = OP_NONE;
        E_A     = '0;
        E_B     = '0;
        m_hi    = '0;
        m_lo    = '0;
        repeat (2) tick();

        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_out", 64'(E_MDUOut), 64'd0);
        reset_n = 1'b1;
        tick();

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_norm", OP_DIVU, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E);

        // Non-start op with E_Start is ignored.
        issue(OP_MFHI, 32'd1, 32'd1);
        check("nonstart_busy", 64'(Busy), 64'd0);

        move_to(OP_MTHI, 32'h1234_5678);
        check("mthi_busy", 64'(Busy), 64'd0);
        E_MDUOp = OP_MFHI;
        #1;
        check("mfhi_out", 64'(E_MDUOut), 64'h1234_5678);
        E_MDUOp = OP_NONE;
        move_to(OP_MTLO, 32'hAABB_CCDD);
        E_MDUOp = OP_MFLO;
        #1;
        check("mflo_out", 64'(E_MDUOut), 64'hAABB_CCDD);
        E_MDUOp = OP_NONE;
        #1;
        check("none_out", 64'(E_MDUOut), 64'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'hAABB_CCDD;

        // MTLO presented mid-run must not touch LO.
        issue(OP_MULT, 32'd2, 32'd3);
        tick();
        move_to(OP_MTLO, 32'hDEAD_BEEF);
        repeat (10) tick();
        check("mtlo_run_busy", 64'(Busy), 64'd0);
        check("mtlo_run_lo", 64'(LO), 64'd6);
        check("mtlo_run_hi", 64'(HI), 64'd0);

        // Reset during the fourth RUN cycle of a divide aborts it.
        issue(OP_DIV, 32'd100, 32'd3);
        repeat (3) tick();
        check("abort_pre_busy", 64'(Busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        tick();
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad = 1'b1;
        end
        check("abort_no_late_commit", 64'(bad), 64'd0);
        m_hi = '0;
        m_lo = '0;

        move_to(OP_MTHI, 32'd0);
        move_to(OP_MTLO, 32'hFFFF_FFFF);
        m_lo = 32'hFFFF_FFFF;
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 32'h0000_0001, 32'h0000_0000);
        run_op("msub", OP_MSUB, 32'd2, 32'hFFFF_FFFF, 5, 32'h0000_0001, 32'h0000_0002);
`else
        issue(OP_MADDU, 32'd1, 32'd1);
        check("maddu_off_busy", 64'(Busy), 64'd0);
        repeat (6) tick();
        check("maddu_off_hi", 64'(HI), 64'd0);
        check("maddu_off_lo", 64'(LO), 64'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
